formula_sweep_ctrl: RTL and testbench
=====================================

# formula_sweep_ctrl

Sequencer that exhaustively checks a combinational benchmark formula by driving its universal (x) and existential (i) input vectors. For each x assignment it searches i assignments until the formula evaluates 1, which is a witness. It reports whether every x has a witness (realizability), the first x without one, and run statistics. It sits between a bench or host harness and one instance of a generated formula module, replacing software enumeration during result checking.

## Interface
- NX, 4, number of universal (x) formula inputs, 1..16
- NI, 9, number of existential (i) formula inputs, 1..16
- EVAL_LAT, 0, cycles between a vector change and a valid formula_out, 0..7
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a sweep; sampled only in IDLE
- abort  in  1  terminate the sweep; sampled only in EVAL
- stop_on_fail  in  1  end the sweep at the first x with no witness; sampled at start
- formula_out  in  1  output of the formula under test
- x_vec  out  NX  x assignment driven to the formula (registered)
- i_vec  out  NI  i assignment driven to the formula (registered)
- busy  out  1  high from the start-accepting edge until the sweep ends
- done  out  1  one-cycle pulse at normal completion
- aborted  out  1  last sweep ended by abort; held until next start
- realizable  out  1  every x visited so far has a witness
- fail_x  out  NX  first x found without a witness (valid when realizable=0)
- witness_count  out  NX+1  number of x with a witness
- eval_count  out  NX+NI+1  number of formula_out samples taken

## Operation
- States: IDLE, EVAL, DONE. State encoding lives in the package.
- IDLE with start=1 at an edge:
  - x_vec, i_vec, wait_cnt, witness_count, eval_count, fail_x, aborted are cleared; realizable is set to 1.
  - stop_on_fail is latched, busy goes to 1, and the state moves to EVAL.
- EVAL:
  - If wait_cnt<EVAL_LAT, wait_cnt increments.
  - Otherwise formula_out is sampled, eval_count increments, and wait_cnt is cleared.
  - formula_out=1: witness_count increments and x advances.
  - formula_out=0 and i_vec≠all-ones: i_vec increments.
  - formula_out=0 and i_vec=all-ones (i wrap): realizable clears. fail_x is loaded only if realizable was still 1. If the latched stop_on_fail is set, go to DONE; otherwise x advances.
  - x advance: if x_vec=all-ones, go to DONE. Otherwise x_vec increments and i_vec clears.
- abort=1 in EVAL takes priority over sampling. It sets aborted and busy=0, goes to IDLE, and does not pulse done. Status outputs keep their partial values.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- start is ignored outside IDLE. With start held high, a new sweep begins on the edge after DONE.
- x_vec and i_vec hold their last values in IDLE and DONE.
- Counters never overflow. The maximum eval_count is 2^(NX+NI), which fits the port width.

## Timing
- Reset values: state IDLE, all outputs 0 except realizable=1.
- Reset asserted mid-sweep returns everything to reset values immediately. No done is produced.
- Each evaluation takes EVAL_LAT+1 cycles. x_vec and i_vec are stable for the whole evaluation.
- With N total evaluations, done is high in the cycle after edge N·(EVAL_LAT+1), counting the start-accepting edge as 0.
- A worst-case sweep is 2^(NX+NI)·(EVAL_LAT+1)+1 cycles.

## Structure
- Package formula_sweep_pkg holds:
  - the state enum typedef (IDLE, EVAL, DONE);
  - localparams for the maximum supported NX and NI and the EVAL_LAT width.
- One sub-module, eval_wait_timer: a loadable down-counter that issues a sample strike every EVAL_LAT+1 cycles while enabled. All remaining control stays in formula_sweep_ctrl.

## Test plan
- NX=2, NI=2, EVAL_LAT=0, stub formula_out=(i_vec==x_vec), start pulse -> 10 evaluations; witness_count=4, realizable=1, done 10 cycles after start, busy high for exactly those cycles.
- Same parameters, stub formula_out=(x_vec≠2 && i_vec==0), stop_on_fail=0 -> eval_count=7, witness_count=3, realizable=0, fail_x=2, x_vec=3 at done.
- Same stub with stop_on_fail=1 -> eval_count=6, witness_count=2, fail_x=2, done after 6 evaluations, x_vec=2 at done.
- EVAL_LAT=2, stub formula_out=1 -> 4 evaluations; each x held 3 cycles; done 12 cycles after start; eval_count=4.
- abort raised at the 3rd EVAL cycle -> busy falls next edge, no done, aborted=1, partial counts retained. A following start clears aborted and runs fully.
- rst_n pulled low mid-sweep, including between clock edges -> outputs reset asynchronously. start pulsed during busy, and held through DONE -> ignored while busy, restarted on the edge after DONE.

Source files
------------

// File: rtl/formula_sweep_pkg.sv
// Shared types and limits for the formula sweep sequencer.
package formula_sweep_pkg;

    // Sequencer states; the encoding is fixed here so checkers can bind to it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Largest supported universal / existential vector widths.
    localparam int MAX_NX = 16;
    localparam int MAX_NI = 16;

    // EVAL_LAT ranges 0..7, so the wait counter needs three bits.
    localparam int MAX_EVAL_LAT = 7;
    localparam int LAT_W        = 3;

endpackage

// File: rtl/formula_sweep_ctrl_eval_wait_timer.sv
// Loadable down-counter that strikes once every EVAL_LAT+1 enabled cycles,
// marking the cycle in which formula_out is settled and may be sampled.
module eval_wait_timer
    import formula_sweep_pkg::*;
#(
    parameter int EVAL_LAT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic strike
);

    localparam logic [LAT_W-1:0] RELOAD = LAT_W'(EVAL_LAT);

    logic [LAT_W-1:0] cnt;

    // A strike happens on the last enabled cycle of each evaluation window.
    assign strike = en && (cnt == '0);

    // Reload at sweep start and after every strike; count down while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RELOAD;
        end else if (load || strike) begin
            cnt <= RELOAD;
        end else if (en) begin
            cnt <= cnt - LAT_W'(1);
        end
    end

endmodule

// File: rtl/formula_sweep_ctrl.sv
// Exhaustive forall-x / exists-i sweep of a combinational formula.
// For each x it walks i until formula_out=1 (a witness), collecting
// realizability, the first failing x and evaluation statistics.
//
// Host handshake: start is a request that is only accepted in IDLE; the
// accepting edge raises busy. busy stays high until the sweep ends, which is
// either a one-cycle done pulse (normal end) or aborted=1 with no done.
module formula_sweep_ctrl
    import formula_sweep_pkg::*;
#(
    parameter int NX       = 4,
    parameter int NI       = 9,
    parameter int EVAL_LAT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             stop_on_fail,
    input  logic             formula_out,
    output logic [NX-1:0]    x_vec,
    output logic [NI-1:0]    i_vec,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             realizable,
    output logic [NX-1:0]    fail_x,
    output logic [NX:0]      witness_count,
    output logic [NX+NI:0]   eval_count
);

    localparam int WC_W = NX + 1;
    localparam int EC_W = NX + NI + 1;

    // Current sequencer state; kept as a named signal for external checkers.
    state_t state;
    logic   stop_q;

    logic   timer_load;
    logic   timer_en;
    logic   strike;
    logic   i_wrap;
    logic   x_last;
    logic   fail_now;
    logic   adv_x;
    logic   finish;

    eval_wait_timer #(
        .EVAL_LAT (EVAL_LAT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load),
        .en     (timer_en),
        .strike (strike)
    );

    // Decode what the current sample (if any) does to the sweep.
    always_comb begin
        timer_load = (state == ST_IDLE) && start;
        // abort wins over sampling, so the timer is frozen in an abort cycle.
        timer_en   = (state == ST_EVAL) && !abort;
        i_wrap     = (i_vec == {NI{1'b1}});
        x_last     = (x_vec == {NX{1'b1}});
        fail_now   = strike && !formula_out && i_wrap;
        adv_x      = (strike && formula_out) || (fail_now && !stop_q);
        finish     = (adv_x && x_last) || (fail_now && stop_q);
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            stop_q        <= 1'b0;
            x_vec         <= '0;
            i_vec         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            realizable    <= 1'b1;
            fail_x        <= '0;
            witness_count <= '0;
            eval_count    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        x_vec         <= '0;
                        i_vec         <= '0;
                        witness_count <= '0;
                        eval_count    <= '0;
                        fail_x        <= '0;
                        aborted       <= 1'b0;
                        realizable    <= 1'b1;
                        stop_q        <= stop_on_fail;
                        busy          <= 1'b1;
                        state         <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (strike) begin
                        eval_count <= eval_count + EC_W'(1);
                        if (formula_out) begin
                            witness_count <= witness_count + WC_W'(1);
                        end else if (!i_wrap) begin
                            i_vec <= i_vec + NI'(1);
                        end else begin
                            realizable <= 1'b0;
                            // Only the first x without a witness is reported.
                            if (realizable) begin
                                fail_x <= x_vec;
                            end
                        end
                        if (finish) begin
                            // Vectors hold their final values through DONE.
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else if (adv_x) begin
                            x_vec <= x_vec + NX'(1);
                            i_vec <= '0;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_formula_sweep_ctrl.sv
// Bench for formula_sweep_ctrl: two instances (EVAL_LAT 0 and 2) driven by
// truth-table formula stubs, checked every cycle against a sweep-level model.
module tb_formula_sweep_ctrl;

    localparam int NX   = 2;
    localparam int NI   = 2;
    localparam int NV   = 1 << (NX + NI);
    localparam int LAT0 = 0;
    localparam int LAT1 = 2;

    typedef struct packed {
        logic            busy;
        logic            done;
        logic            aborted;
        logic            realizable;
        logic [NX-1:0]   fail_x;
        logic [NX-1:0]   x;
        logic [NI-1:0]   i;
        logic [NX:0]     wc;
        logic [NX+NI:0]  ec;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic            start [2];
    logic            abort [2];
    logic            sof [2];
    logic            fo [2];
    logic [NV-1:0]   tbl [2];
    logic [NX-1:0]   x_vec [2];
    logic [NI-1:0]   i_vec [2];
    logic            busy [2];
    logic            done [2];
    logic            aborted [2];
    logic            realizable [2];
    logic [NX-1:0]   fail_x [2];
    logic [NX:0]     witness_count [2];
    logic [NX+NI:0]  eval_count [2];

    int vectors = 0;
    int miscompares = 0;

    // model of each sweep: the ordered list of (x, i, result) evaluations
    logic [NX-1:0] m_x [2][NV];
    logic [NI-1:0] m_i [2][NV];
    bit            m_w [2][NV];
    int            m_n [2];
    int            m_e [2];
    int            m_ab_e [2];
    bit            m_valid [2];
    bit            m_ab [2];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // formula stubs: truth tables indexed by {x, i}
    assign fo[0] = tbl[0][{x_vec[0], i_vec[0]}];
    assign fo[1] = tbl[1][{x_vec[1], i_vec[1]}];

    formula_sweep_ctrl #(.NX(NX), .NI(NI), .EVAL_LAT(LAT0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
        .stop_on_fail(sof[0]), .formula_out(fo[0]), .x_vec(x_vec[0]),
        .i_vec(i_vec[0]), .busy(busy[0]), .done(done[0]), .aborted(aborted[0]),
        .realizable(realizable[0]), .fail_x(fail_x[0]),
        .witness_count(witness_count[0]), .eval_count(eval_count[0])
    );

    formula_sweep_ctrl #(.NX(NX), .NI(NI), .EVAL_LAT(LAT1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
        .stop_on_fail(sof[1]), .formula_out(fo[1]), .x_vec(x_vec[1]),
        .i_vec(i_vec[1]), .busy(busy[1]), .done(done[1]), .aborted(aborted[1]),
        .realizable(realizable[1]), .fail_x(fail_x[1]),
        .witness_count(witness_count[1]), .eval_count(eval_count[1])
    );

    // ---------------- model ----------------
    function automatic void build(input int d);
        int n;
        bit got;
        n = 0;
        for (int x = 0; x < (1 << NX); x++) begin
            got = 1'b0;
            for (int i = 0; i < (1 << NI); i++) begin
                m_x[d][n] = NX'(x);
                m_i[d][n] = NI'(i);
                m_w[d][n] = tbl[d][x * (1 << NI) + i];
                n++;
                if (m_w[d][n-1]) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got && sof[d]) break;
        end
        m_n[d] = n;
    endfunction

    // outputs seen e edges after the start-accepting edge of an unaborted sweep
    function automatic exp_t model_at(input int d, input int e);
        exp_t r;
        int per, n, k, last;
        per  = (d == 0) ? LAT0 + 1 : LAT1 + 1;
        n    = m_n[d];
        k    = (e < n * per) ? e / per : n;
        last = (k < n) ? k : n - 1;
        r = '0;
        r.realizable = 1'b1;
        r.busy = (e < n * per);
        r.done = (e == n * per);
        r.x    = m_x[d][last];
        r.i    = m_i[d][last];
        r.ec   = (NX+NI+1)'(k);
        for (int j = 0; j < k; j++) begin
            if (m_w[d][j]) begin
                r.wc = r.wc + (NX+1)'(1);
            end else if (m_i[d][j] == {NI{1'b1}}) begin
                if (r.realizable) r.fail_x = m_x[d][j];
                r.realizable = 1'b0;
            end
        end
        return r;
    endfunction

    function automatic exp_t expected(input int d);
        exp_t r;
        if (!m_valid[d]) begin
            r = '0;
            r.realizable = 1'b1;
        end else if (m_ab[d] && m_e[d] >= m_ab_e[d]) begin
            r = model_at(d, m_ab_e[d] - 1);
            r.busy    = 1'b0;
            r.done    = 1'b0;
            r.aborted = 1'b1;
        end else begin
            r = model_at(d, m_e[d]);
        end
        return r;
    endfunction

    function automatic bit model_idle(input int d);
        int per;
        per = (d == 0) ? LAT0 + 1 : LAT1 + 1;
        return !m_valid[d] || m_ab[d] || (m_e[d] > m_n[d] * per);
    endfunction

    // model time advance: follows start/abort/reset at sweep level
    initial forever begin
        @(posedge clk or negedge rst_n);
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_valid[d] = 1'b0;
                m_ab[d]    = 1'b0;
            end else if (model_idle(d)) begin
                if (start[d]) begin
                    build(d);
                    m_valid[d] = 1'b1;
                    m_ab[d]    = 1'b0;
                    m_e[d]     = 0;
                end else begin
                    m_e[d] = m_e[d] + 1;
                end
            end else begin
                if (abort[d] && m_e[d] < m_n[d] * ((d == 0) ? LAT0 + 1 : LAT1 + 1)) begin
                    m_ab[d]   = 1'b1;
                    m_ab_e[d] = m_e[d] + 1;
                end
                m_e[d] = m_e[d] + 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d t=%0t got=%0h expected=%0h", nm, d, $time, act, exp);
        end
    endtask

    // every-cycle compare of both instances against the model
    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            exp_t ex;
            ex = expected(d);
            chk("busy",          d, 32'(busy[d]),          32'(ex.busy));
            chk("done",          d, 32'(done[d]),          32'(ex.done));
            chk("aborted",       d, 32'(aborted[d]),       32'(ex.aborted));
            chk("realizable",    d, 32'(realizable[d]),    32'(ex.realizable));
            chk("fail_x",        d, 32'(fail_x[d]),        32'(ex.fail_x));
            chk("x_vec",         d, 32'(x_vec[d]),         32'(ex.x));
            chk("i_vec",         d, 32'(i_vec[d]),         32'(ex.i));
            chk("witness_count", d, 32'(witness_count[d]), 32'(ex.wc));
            chk("eval_count",    d, 32'(eval_count[d]),    32'(ex.ec));
        end
    end

    // ---------------- driver tasks ----------------
    // pulse start for one cycle; returns at the first negedge after acceptance
    task automatic launch(input int d, input logic [NV-1:0] t, input bit s);
        @(negedge clk);
        tbl[d]   = t;
        sof[d]   = s;
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
    endtask

    // edge index of done (start edge = 0) and number of busy cycles before it
    task automatic wait_done(input int d, output int e, output int bc);
        e  = 0;
        bc = 0;
        while (!done[d] && e < 400) begin
            if (busy[d]) bc++;
            @(negedge clk);
            e++;
        end
        if (!done[d]) chk("done_timeout", d, 32'(done[d]), 32'd1);
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while ((busy[d] || done[d]) && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (busy[d] || done[d]) chk("idle_timeout", d, 32'(busy[d]), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int e, bc, len;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0;
            abort[d] = 1'b0;
            sof[d]   = 1'b0;
            tbl[d]   = '0;
        end
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_realizable", 0, 32'(realizable[0]), 32'd1);
        chk("rst_eval_count", 1, 32'(eval_count[1]), 32'd0);

        // i==x: 1+2+3+4 = 10 evaluations, every x has a witness
        launch(0, 16'h8421, 1'b0);
        wait_done(0, e, bc);
        chk("eq_done_edge", 0, 32'(e), 32'd10);
        chk("eq_busy_cycles", 0, 32'(bc), 32'd10);
        chk("eq_witness", 0, 32'(witness_count[0]), 32'd4);
        chk("eq_realizable", 0, 32'(realizable[0]), 32'd1);
        chk("eq_evals", 0, 32'(eval_count[0]), 32'd10);
        wait_idle(0);

        // witness only at i=0 for x!=2; x=2 fails after 4 tries
        launch(0, 16'h1011, 1'b0);
        wait_done(0, e, bc);
        chk("nx2_evals", 0, 32'(eval_count[0]), 32'd7);
        chk("nx2_witness", 0, 32'(witness_count[0]), 32'd3);
        chk("nx2_realizable", 0, 32'(realizable[0]), 32'd0);
        chk("nx2_fail_x", 0, 32'(fail_x[0]), 32'd2);
        chk("nx2_x_at_done", 0, 32'(x_vec[0]), 32'd3);
        wait_idle(0);

        // same formula, stop at first failure
        launch(0, 16'h1011, 1'b1);
        wait_done(0, e, bc);
        chk("sof_done_edge", 0, 32'(e), 32'd6);
        chk("sof_evals", 0, 32'(eval_count[0]), 32'd6);
        chk("sof_witness", 0, 32'(witness_count[0]), 32'd2);
        chk("sof_fail_x", 0, 32'(fail_x[0]), 32'd2);
        chk("sof_x_at_done", 0, 32'(x_vec[0]), 32'd2);
        wait_idle(0);

        // latency 2, always-true formula: 4 evaluations of 3 cycles
        launch(1, 16'hFFFF, 1'b0);
        wait_done(1, e, bc);
        chk("lat_done_edge", 1, 32'(e), 32'd12);
        chk("lat_evals", 1, 32'(eval_count[1]), 32'd4);
        wait_idle(1);

        // abort sampled at the 3rd EVAL cycle
        launch(0, 16'h8421, 1'b0);
        @(negedge clk);
        @(negedge clk);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        chk("ab_aborted", 0, 32'(aborted[0]), 32'd1);
        chk("ab_busy", 0, 32'(busy[0]), 32'd0);
        chk("ab_evals", 0, 32'(eval_count[0]), 32'd2);
        chk("ab_witness", 0, 32'(witness_count[0]), 32'd1);
        chk("ab_i_vec", 0, 32'(i_vec[0]), 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("ab_no_done", 0, 32'(done[0]), 32'd0);
        end
        launch(0, 16'h8421, 1'b0);
        chk("ab_cleared", 0, 32'(aborted[0]), 32'd0);
        wait_done(0, e, bc);
        chk("ab_rerun_evals", 0, 32'(eval_count[0]), 32'd10);
        wait_idle(0);

        // start pulsed while busy is ignored
        launch(0, 16'hFFFF, 1'b0);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0, e, bc);
        chk("busy_start_edge", 0, 32'(e), 32'd3);
        chk("busy_start_evals", 0, 32'(eval_count[0]), 32'd4);
        wait_idle(0);

        // start held through DONE: IDLE for one cycle, then a new sweep
        @(negedge clk);
        tbl[0]   = 16'hFFFF;
        start[0] = 1'b1;
        @(negedge clk);
        wait_done(0, e, bc);
        chk("hold_done_edge", 0, 32'(e), 32'd4);
        @(negedge clk);
        chk("hold_idle_gap", 0, 32'(busy[0]), 32'd0);
        @(negedge clk);
        chk("hold_restart", 0, 32'(busy[0]), 32'd1);
        start[0] = 1'b0;
        wait_idle(0);

        // asynchronous reset between clock edges, mid-sweep
        launch(0, 16'h8421, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 0, 32'(busy[0]), 32'd0);
        chk("arst_evals", 0, 32'(eval_count[0]), 32'd0);
        chk("arst_x_vec", 0, 32'(x_vec[0]), 32'd0);
        chk("arst_realizable", 0, 32'(realizable[0]), 32'd1);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // randomized sweeps with stray start and abort pulses
        for (int it = 0; it < 30; it++) begin
            int d;
            d = $urandom_range(0, 1);
            @(negedge clk);
            tbl[d]   = NV'($urandom & $urandom);
            sof[d]   = 1'($urandom_range(0, 1));
            start[d] = 1'b1;
            len = $urandom_range(20, 120);
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                start[d] = ($urandom_range(0, 7) == 0);
                abort[d] = ($urandom_range(0, 29) == 0);
            end
            @(negedge clk);
            start[d] = 1'b0;
            abort[d] = 1'b0;
            wait_idle(d);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
